// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default divider,
// frame width and a 2-of-3 majority helper used by the optional
// UART_RX_MAJORITY_EN sampling mode.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  localparam int UART_BAUD_DIV  = 2604;
  localparam int UART_DATA_BITS = 8;

  // 2-of-3 vote, used to filter single-clock glitches at a sample point
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is
// a parameter so an idle-high serial line can come out of reset as idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with fixed-divider mid-bit sampling, start-glitch
// rejection, framing-error and overrun flags, and a set/clear rdy flag.
// Optional macro UART_RX_MAJORITY_EN: each sample point becomes a 2-of-3
// vote around the expiry clock, which delays every decision by one clock.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV  // clocks per bit, must be >= 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      clr_rdy,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rdy,
  output logic                      frm_err,
  output logic                      overrun
);

  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam int BIT_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV);
  localparam logic [CNT_W-1:0] CNT_BAUD = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_t state_reg, state_next;

  logic                      rx_s;
  logic                      line;       // line level the FSM tracks
  logic                      line_prev;  // that level one clock earlier
  logic                      samp;       // value taken at a sample point
  logic [CNT_W-1:0]          cnt_reg;
  logic [BIT_W-1:0]          bit_cnt_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      expired;

  // datapath controls from the output decoder
  logic load_half;
  logic load_baud;
  logic cnt_dec;
  logic shift_en;
  logic bit_clr;
  logic byte_ok;
  logic frm_set;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Together with rx_s these two flops form the 3-deep history. The FSM
  // runs on the history delayed by one clock, so at its expiry clock the
  // vote covers expiry-1, expiry and expiry+1 of that delayed stream.
  logic [1:0] hist_reg;

  // Shift rx_s into the history every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign line      = hist_reg[0];
  assign line_prev = hist_reg[1];
  assign samp      = maj3(hist_reg[1], hist_reg[0], rx_s);
`else
  logic rx_prev_reg;

  // Remember the previous synchronized level for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_reg <= 1'b1;
    end else begin
      rx_prev_reg <= rx_s;
    end
  end

  assign line      = rx_s;
  assign line_prev = rx_prev_reg;
  assign samp      = rx_s;
`endif

  // The counter holds the clocks remaining in the current interval; the
  // last clock of the interval (count of 1) is the sample point.
  assign expired = (cnt_reg == CNT_ONE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (line_prev && !line) begin
          state_next = START;
        end
      end
      START: begin
        if (expired) begin
          state_next = samp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (expired && (bit_cnt_reg == LAST_BIT)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (expired) begin
          state_next = samp ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (line) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode: per-state datapath controls
  always_comb begin
    load_half = 1'b0;
    load_baud = 1'b0;
    cnt_dec   = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    byte_ok   = 1'b0;
    frm_set   = 1'b0;
    case (state_reg)
      IDLE: begin
        load_half = line_prev && !line;
      end
      START: begin
        cnt_dec = 1'b1;
        if (expired && !samp) begin
          load_baud = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      DATA: begin
        cnt_dec = 1'b1;
        if (expired) begin
          shift_en  = 1'b1;
          load_baud = 1'b1;
        end
      end
      STOP: begin
        cnt_dec = 1'b1;
        if (expired) begin
          byte_ok = samp;
          frm_set = !samp;
        end
      end
      default: begin
      end
    endcase
  end

  // Baud counter: explicit reload at every expiry, never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load_half) begin
      cnt_reg <= CNT_HALF;
    end else if (load_baud) begin
      cnt_reg <= CNT_BAUD;
    end else if (cnt_dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

  // Data bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (bit_clr) begin
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
      end
      if (shift_en) begin
        shift_reg <= {samp, shift_reg[UART_DATA_BITS-1:1]};
      end
    end
  end

  // Output flags: a completing byte beats a coincident clr_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (byte_ok) begin
        rx_data <= shift_reg;
        rdy     <= 1'b1;
        frm_err <= 1'b0;
      end else begin
        if (clr_rdy) begin
          rdy <= 1'b0;
        end
        if (frm_set) begin
          frm_err <= 1'b1;
        end
      end
      if (byte_ok && rdy && !clr_rdy) begin
        overrun <= 1'b1;
      end else if (clr_rdy) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with a short divider so whole frames
// stay cheap. Honours UART_RX_MAJORITY_EN for the expected latency.
module tb_uart_rx_byte;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // rx pin fall to rdy high: 2 sync flops + edge detect + half + 9 bits
  localparam int LAT = HALF + 9 * BAUD + 3 + EXTRA;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       overrun;

  int errors;
  int checks;
  int cyc;
  int frame_start_cyc;
  int rise_cyc;
  logic rdy_q;

  uart_rx_byte #(
    .BAUD_DIV(BAUD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // record the cycle on which rdy rises
  always @(negedge clk) begin
    if (rdy && !rdy_q) rise_cyc = cyc;
    rdy_q = rdy;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    @(posedge clk); #1;
    rx = 1'b0;
    frame_start_cyc = cyc;
    repeat (BAUD) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(posedge clk); #1;
    end
    rx = stop;
    repeat (BAUD + extra_low) @(posedge clk); #1;
    rx = 1'b1;
    $display("frame 0x%02h stop=%0b: rx_data=0x%02h rdy=%0b frm_err=%0b overrun=%0b",
             b, stop, rx_data, rdy, frm_err, overrun);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; clr_rdy = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst_n = 1'b1;
    idle(HALF);
  endtask

  task automatic test_single();
    int lat;
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 0);
    lat = rise_cyc - frame_start_cyc;
    checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rx_data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", rdy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL single_frm_err: got %b want 0", frm_err); end
    pulse_clr();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL single_clr_rdy: got %b want 0", rdy); end
    idle(HALF);
  endtask

  task automatic test_sequence();
    logic [7:0] seq [3];
    seq[0] = 8'hA5; seq[1] = 8'hE7; seq[2] = 8'h24;
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b1, 0);
      checks++; if (rx_data !== seq[i]) begin errors++; $display("FAIL seq_data[%0d]: got %h want %h", i, rx_data, seq[i]); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL seq_rdy[%0d]: got %b want 1", i, rdy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL seq_overrun[%0d]: got %b want 0", i, overrun); end
      pulse_clr();
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL seq_clr[%0d]: got %b want 0", i, rdy); end
      idle(HALF);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hE7, 1'b1, 0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_overrun: got %b want 0", overrun); end
    send_frame(8'h24, 1'b1, 0);
    checks++; if (rx_data !== 8'h24) begin errors++; $display("FAIL b2b_data: got %h want 24", rx_data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    pulse_clr();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_clr_rdy: got %b want 0", rdy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr_overrun: got %b want 0", overrun); end
    idle(HALF);
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx = 1'b1;
    idle(2 * BAUD);
    $display("glitch: rdy=%0b frm_err=%0b", rdy, frm_err);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL glitch_frm_err: got %b want 0", frm_err); end
    send_frame(8'h24, 1'b1, 0);
    checks++; if (rx_data !== 8'h24) begin errors++; $display("FAIL glitch_next_data: got %h want 24", rx_data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL glitch_next_rdy: got %b want 1", rdy); end
    pulse_clr();
    idle(HALF);
  endtask

  task automatic test_frame_error();
    send_frame(8'h5A, 1'b0, 5 * BAUD);
    idle(BAUD);
    checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frm_err); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ferr_rdy: got %b want 0", rdy); end
    checks++; if (rx_data !== 8'h24) begin errors++; $display("FAIL ferr_data_kept: got %h want 24", rx_data); end
    send_frame(8'hA5, 1'b1, 0);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ferr_next_rdy: got %b want 1", rdy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", frm_err); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_next_data: got %h want a5", rx_data); end
    idle(HALF);
  endtask

  task automatic test_clr_collision();
    // rdy is still set from the previous byte; clr_rdy lands on the stop decision
    fork
      send_frame(8'h3C, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk); #1;
        clr_rdy = 1'b1;
        @(posedge clk); #1;
        clr_rdy = 1'b0;
      end
    join
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL coll_data: got %h want 3c", rx_data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy: got %b want 1", rdy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b want 0", overrun); end
    idle(HALF);
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bits = {1'b1, 8'hA5, 1'b0};  // bit 0 is the start bit
    @(posedge clk); #1;
    for (int p = 0; p < 10; p++) begin
      rx = bits[p];
      if (p == 4) begin
        repeat (HALF) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", rdy); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL midrst_frm_err: got %b want 0", frm_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        repeat (BAUD - HALF) @(posedge clk); #1;
      end else if (p == 8) begin
        repeat (HALF) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (BAUD - HALF) @(posedge clk); #1;
      end else begin
        repeat (BAUD) @(posedge clk); #1;
      end
    end
    rx = 1'b1;
    idle(2 * BAUD);
    $display("reset mid-frame: rdy=%0b frm_err=%0b", rdy, frm_err);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_no_rdy: got %b want 0", rdy); end
    send_frame(8'h81, 1'b1, 0);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL midrst_next_data: got %h want 81", rx_data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_next_rdy: got %b want 1", rdy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL midrst_next_frm_err: got %b want 0", frm_err); end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; rise_cyc = -1; rdy_q = 1'b0;
    frame_start_cyc = 0;
    rst_n = 1'b0; rx = 1'b1; clr_rdy = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_clr_collision();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
